reg_wb_queue: RTL

//   Write-back queue in front of the single register-file write port.
//   - Accepts register-write requests (addr, data) through a valid/ready handshake.
//   - Buffers them in order and drains one per cycle onto the register file's
//     wr_en/wr_addr/wr_data port.
//   - Provides forwarding lookups on both read addresses, so decode sees writes that
//     are still pending in the queue.

---
 rtl/reg_wb_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the single register-file write port.
// It drains one entry per cycle and forwards pending writes to both decode read ports.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int SIZE  = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [SIZE-1:0]            in_data,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [SIZE-1:0]            wr_data,
  input  logic [AW-1:0]              rd_addr1,
  input  logic [AW-1:0]              rd_addr2,
  output logic                       fwd_hit1,
  output logic [SIZE-1:0]            fwd_data1,
  output logic                       fwd_hit2,
  output logic [SIZE-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]   addr_mem [DEPTH];
  logic [SIZE-1:0] data_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   occ;
  logic [AW-1:0]   last_addr;
  logic [SIZE-1:0] last_data;
  logic            full, empty, push, pop;

  assign full     = (occ == CW'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = !empty;
  assign count    = occ;

  // The register file always accepts, so the head is consumed at every non-empty edge.
  assign wr_en   = !empty;
  assign wr_addr = empty ? last_addr : addr_mem[rd_ptr];
  assign wr_data = empty ? last_data : data_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_addr <= addr_mem[rd_ptr];
        last_data <= data_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < occ) begin
        if (rd_addr1 != '0 && addr_mem[idx] == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end
        if (rd_addr2 != '0 && addr_mem[idx] == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end
      end
    end
  end

endmodule
